// File: rtl/io_pkg.sv
// Shared IO-block types and sizes for the writeback path.
package io_pkg;

  localparam int unsigned IO_WB_PORTS  = 4;
  localparam int unsigned IO_REGADDR_W = 4;
  localparam int unsigned IO_DATA_W    = 16;

  // Register index whose writebacks carry no architectural effect.
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [IO_REGADDR_W-1:0] dest;
    logic [IO_DATA_W-1:0]    data;
  } io_wb_entry_t;

endpackage

// File: rtl/io_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
module io_rr_picker #(
  parameter  int unsigned PORTCOUNT = 4,
  localparam int unsigned IW        = (PORTCOUNT > 1) ? $clog2(PORTCOUNT) : 1
) (
  input  logic [PORTCOUNT-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [PORTCOUNT-1:0] grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 any_grant
);

  localparam int unsigned SW = IW + 1;

  logic [2*PORTCOUNT-1:0] dbl;
  logic [PORTCOUNT-1:0]   rot;
  logic [IW-1:0]          off;
  logic [SW-1:0]          sum;

  // Rotate so ptr lands at bit 0, scan for the lowest set bit, then un-rotate the index.
  always_comb begin
    dbl       = {req, req} >> ptr;
    rot       = dbl[PORTCOUNT-1:0];
    any_grant = 1'b0;
    off       = '0;
    for (int i = PORTCOUNT - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any_grant = 1'b1;
        off       = IW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(PORTCOUNT)) begin
      sum = sum - SW'(PORTCOUNT);
    end
    grant_idx = sum[IW-1:0];
    grant     = '0;
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/io_writeback_arbiter.sv
// Merges the clock-generation writeback channels into one registered IO writeback port.
module io_writeback_arbiter
  import io_pkg::*;
#(
  parameter  int unsigned DATABITWIDTH    = IO_DATA_W,
  parameter  int unsigned PORTCOUNT       = IO_WB_PORTS,
  parameter  int unsigned REGADDRBITWIDTH = IO_REGADDR_W,
  parameter  bit          DROPZERODEST    = 1'b1,
  localparam int unsigned SRCW            = (PORTCOUNT > 1) ? $clog2(PORTCOUNT) : 1
) (
  input  logic                                      clk,
  input  logic                                      async_rst_n,
  input  logic                                      clk_en,
  input  logic [PORTCOUNT-1:0]                      InACK,
  output logic [PORTCOUNT-1:0]                      InREQ,
  input  logic [PORTCOUNT-1:0][REGADDRBITWIDTH-1:0] InDestReg,
  input  logic [PORTCOUNT-1:0][DATABITWIDTH-1:0]    InData,
  output logic                                      OutACK,
  input  logic                                      OutREQ,
  output logic [REGADDRBITWIDTH-1:0]                OutDestReg,
  output logic [DATABITWIDTH-1:0]                   OutData,
  output logic [SRCW-1:0]                           OutSrcPort
);

  logic                       out_valid_q, out_valid_d;
  logic [REGADDRBITWIDTH-1:0] out_dest_q, out_dest_d;
  logic [DATABITWIDTH-1:0]    out_data_q, out_data_d;
  logic [SRCW-1:0]            out_src_q, out_src_d;
  logic [SRCW-1:0]            ptr_q, ptr_d;

  logic [PORTCOUNT-1:0] grant;
  logic [SRCW-1:0]      grant_idx;
  logic                 any_grant;
  logic                 can_accept;
  logic                 accept;
  logic                 drop;

  io_rr_picker #(
    .PORTCOUNT (PORTCOUNT)
  ) u_picker (
    .req       (InACK),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A full stage drained this cycle may be refilled in the same cycle.
  assign can_accept = async_rst_n & clk_en & (~out_valid_q | OutREQ);
  assign accept     = can_accept & any_grant;
  assign InREQ      = can_accept ? grant : '0;
  assign drop       = DROPZERODEST &&
                      (InDestReg[grant_idx] == REGADDRBITWIDTH'(ZERO_REG));

  always_comb begin
    out_valid_d = out_valid_q;
    out_dest_d  = out_dest_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_dest_d  = InDestReg[grant_idx];
      out_data_d  = InData[grant_idx];
      out_src_d   = grant_idx;
      out_valid_d = ~drop;
      ptr_d       = (grant_idx == SRCW'(PORTCOUNT - 1)) ? '0 : grant_idx + SRCW'(1);
    end else if (clk_en && out_valid_q && OutREQ) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      out_valid_q <= 1'b0;
      out_dest_q  <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_dest_q  <= out_dest_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OutACK     = out_valid_q;
  assign OutDestReg = out_dest_q;
  assign OutData    = out_data_q;
  assign OutSrcPort = out_src_q;

endmodule
